// File: rtl/oc8051_alu_src_ctrl.sv
// ALU operand-source sequencer: steps the sel1/sel2/sel3 codes for each instruction class.
// Optional sticky protocol-error flag, built only when OC8051_ALU_SRC_CTRL_ERR_EN is defined.
module oc8051_alu_src_ctrl #(
  parameter int MULDIV_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_class,
  input  logic       stall,
  input  logic       mem_ack,
  output logic [2:0] sel1,
  output logic [1:0] sel2,
  output logic       sel3,
  output logic [3:0] step,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] S1_RAM = 3'd0;
  localparam logic [2:0] S1_ACC = 3'd1;
  localparam logic [2:0] S1_OP1 = 3'd2;
  localparam logic [2:0] S1_OP2 = 3'd3;
  localparam logic [2:0] S1_OP3 = 3'd4;
  localparam logic [2:0] S1_PCH = 3'd5;
  localparam logic [2:0] S1_PCL = 3'd6;

  localparam logic [1:0] S2_ZERO = 2'd1;
  localparam logic [1:0] S2_RAM  = 2'd2;
  localparam logic [1:0] S2_OP2  = 2'd3;

  localparam logic S3_DP = 1'b0;
  localparam logic S3_PC = 1'b1;

  localparam logic [5:0] SEL_DFLT = {S1_ACC, S2_ZERO, S3_PC};

  localparam logic [3:0] MD_LAST = 4'(MULDIV_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [3:0] step_q, step_d;
  logic       busy_q, busy_d;
  logic [5:0] sel_q, sel_d;
  logic [3:0] last;

  // Selects {sel1,sel2,sel3} for a class at a given step.
  function automatic logic [5:0] sel_of(
    input logic [2:0] c,
    input logic [3:0] s
  );
    logic [5:0] r;
    r = SEL_DFLT;
    case (c)
      3'd0: r = {S1_ACC, S2_ZERO, S3_PC};
      3'd1: r = {S1_ACC, S2_RAM, S3_PC};
      3'd2: r = {S1_ACC, S2_OP2, S3_PC};
      3'd3: r = (s == 4'd0) ?
                {S1_PCL, S2_ZERO, S3_PC} :
                {S1_PCH, S2_ZERO, S3_PC};
      3'd4: r = {S1_ACC, S2_ZERO, S3_DP};
      3'd5: r = {S1_ACC, S2_ZERO, S3_PC};
      3'd6: r = {S1_ACC, S2_RAM, S3_PC};
      3'd7: begin
        if (s == 4'd0)
          r = {S1_OP1, S2_ZERO, S3_PC};
        else if (s == 4'd1)
          r = {S1_OP2, S2_ZERO, S3_PC};
        else
          r = {S1_OP3, S2_ZERO, S3_PC};
      end
      default: r = SEL_DFLT;
    endcase
    return r;
  endfunction

  // Index of the final EXEC step for the latched class.
  always_comb begin
    last = 4'd0;
    case (cls_q)
      3'd3:    last = 4'd1;
      3'd6:    last = MD_LAST;
      3'd7:    last = 4'd2;
      default: last = 4'd0;
    endcase
  end

  // Next-state: accept, advance, wait for memory, or return to idle.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    step_d  = step_q;
    busy_d  = busy_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stall) begin
          cls_d  = op_class;
          step_d = 4'd0;
          busy_d = 1'b1;
          sel_d  = sel_of(op_class, 4'd0);
          if (op_class == 3'd4 || op_class == 3'd5)
            state_d = S_WAIT;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (step_q == last) begin
            state_d = S_IDLE;
            step_d  = 4'd0;
            busy_d  = 1'b0;
            sel_d   = SEL_DFLT;
          end else begin
            step_d = step_q + 4'd1;
            sel_d  = sel_of(cls_q, step_q + 4'd1);
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
          busy_d  = 1'b0;
          sel_d   = SEL_DFLT;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 4'd0;
        busy_d  = 1'b0;
        sel_d   = SEL_DFLT;
      end
    endcase
  end

  // Sequencer registers with asynchronous reset to the idle defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= 3'd0;
      step_q  <= 4'd0;
      busy_q  <= 1'b0;
      sel_q   <= SEL_DFLT;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
    end
  end

  assign done = ((state_q == S_EXEC) && !stall &&
                 (step_q == last)) ||
                ((state_q == S_WAIT) && mem_ack);

  assign sel1 = sel_q[5:3];
  assign sel2 = sel_q[2:1];
  assign sel3 = sel_q[0];
  assign step = step_q;
  assign busy = busy_q;

`ifdef OC8051_ALU_SRC_CTRL_ERR_EN
  logic err_q;

  // Sticky flag: start while busy, or mem_ack outside WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if ((start && busy_q) ||
             (mem_ack && state_q != S_WAIT))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oc8051_alu_src_ctrl.sv
// Bench for oc8051_alu_src_ctrl: directed literal checks plus
// randomized traffic compared every cycle against a sequence-list model.
module tb_oc8051_alu_src_ctrl;

  localparam int MULDIV_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_class;
  logic       stall;
  logic       mem_ack;
  logic [2:0] sel1;
  logic [1:0] sel2;
  logic       sel3;
  logic [3:0] step;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  oc8051_alu_src_ctrl #(.MULDIV_CYC(MULDIV_CYC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_class(op_class), .stall(stall),
    .mem_ack(mem_ack), .sel1(sel1), .sel2(sel2),
    .sel3(sel3), .step(step), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Model: a sequence is a list of (sel1,sel2,sel3) per step.
  int s1q[$];
  int s2q[$];
  int s3q[$];
  bit m_busy = 0;
  bit m_wait = 0;
  int m_idx  = 0;
  bit m_err  = 0;

  task automatic push(input int a, input int b, input int c);
    s1q.push_back(a);
    s2q.push_back(b);
    s3q.push_back(c);
  endtask

  task automatic build(input logic [2:0] c);
    s1q.delete();
    s2q.delete();
    s3q.delete();
    m_wait = 0;
    case (c)
      3'd0: push(1, 1, 1);
      3'd1: push(1, 2, 1);
      3'd2: push(1, 3, 1);
      3'd3: begin push(6, 1, 1); push(5, 1, 1); end
      3'd4: begin push(1, 1, 0); m_wait = 1; end
      3'd5: begin push(1, 1, 1); m_wait = 1; end
      3'd6: for (int k = 0; k < MULDIV_CYC; k++)
              push(1, 2, 1);
      default: begin
        push(2, 1, 1);
        push(3, 1, 1);
        push(4, 1, 1);
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_wait = 0;
      m_idx  = 0;
      m_err  = 0;
    end else begin
      if ((start && m_busy) ||
          (mem_ack && !(m_busy && m_wait)))
        m_err = 1;
      if (!m_busy) begin
        if (start && !stall) begin
          build(op_class);
          m_busy = 1;
          m_idx  = 0;
        end
      end else if (m_wait) begin
        if (mem_ack) m_busy = 0;
      end else if (!stall) begin
        if (m_idx == s1q.size() - 1) m_busy = 0;
        else m_idx++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int e1, e2, e3, es, eb, ed, ee;
    eb = m_busy ? 1 : 0;
    e1 = m_busy ? s1q[m_idx] : 1;
    e2 = m_busy ? s2q[m_idx] : 1;
    e3 = m_busy ? s3q[m_idx] : 1;
    es = m_busy ? m_idx : 0;
    ed = 0;
    if (m_busy && !rst) begin
      if (m_wait) ed = mem_ack ? 1 : 0;
      else ed = (!stall && m_idx == s1q.size() - 1) ? 1 : 0;
    end
`ifdef OC8051_ALU_SRC_CTRL_ERR_EN
    ee = m_err ? 1 : 0;
`else
    ee = 0;
`endif
    checks++;
    if (sel1 !== 3'(e1) || sel2 !== 2'(e2) ||
        sel3 !== 1'(e3) || step !== 4'(es) ||
        busy !== 1'(eb) || done !== 1'(ed) ||
        err !== 1'(ee)) begin
      errors++;
      $display("FAIL cyc t=%0t got s1=%0d s2=%0d s3=%0d st=%0d b=%0d d=%0d e=%0d exp %0d %0d %0d %0d %0d %0d %0d",
               $time, sel1, sel2, sel3, step, busy, done,
               err, e1, e2, e3, es, eb, ed, ee);
    end
  end

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start = 0; op_class = 0;
    stall = 0; mem_ack = 0;
    #1;
    chk("rst_sel1", 8'(sel1), 8'd1);
    chk("rst_sel2", 8'(sel2), 8'd1);
    chk("rst_sel3", 8'(sel3), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_step", 8'(step), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_err",  8'(err),  8'd0);
    tick(); tick();
    rst = 0;
    tick();

    // CALL
    start = 1; op_class = 3;
    tick();
    start = 0;
    #1;
    chk("call0_sel1", 8'(sel1), 8'd6);
    chk("call0_sel2", 8'(sel2), 8'd1);
    chk("call0_busy", 8'(busy), 8'd1);
    chk("call0_step", 8'(step), 8'd0);
    chk("call0_done", 8'(done), 8'd0);
    tick();
    #1;
    chk("call1_sel1", 8'(sel1), 8'd5);
    chk("call1_step", 8'(step), 8'd1);
    chk("call1_done", 8'(done), 8'd1);
    tick();
    #1;
    chk("call_end_busy", 8'(busy), 8'd0);
    chk("call_end_sel1", 8'(sel1), 8'd1);
    tick();

    // Reset during CALL step 1
    start = 1; op_class = 3;
    tick();
    start = 0;
    tick();
    chk("mid_step", 8'(step), 8'd1);
    rst = 1;
    #1;
    chk("mid_sel1", 8'(sel1), 8'd1);
    chk("mid_sel2", 8'(sel2), 8'd1);
    chk("mid_sel3", 8'(sel3), 8'd1);
    chk("mid_busy", 8'(busy), 8'd0);
    chk("mid_step0", 8'(step), 8'd0);
    chk("mid_done", 8'(done), 8'd0);
    tick();
    rst = 0;
    tick();

    // OP3 with stall on step 1
    start = 1; op_class = 7;
    tick();
    start = 0;
    #1;
    chk("op3_s0", 8'(sel1), 8'd2);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("op3_hold_sel1", 8'(sel1), 8'd3);
      chk("op3_hold_done", 8'(done), 8'd0);
      tick();
    end
    stall = 0;
    #1;
    chk("op3_s1_sel1", 8'(sel1), 8'd3);
    chk("op3_s1_done", 8'(done), 8'd0);
    tick();
    #1;
    chk("op3_s2_sel1", 8'(sel1), 8'd4);
    chk("op3_s2_done", 8'(done), 8'd1);
    tick();
    #1;
    chk("op3_end_busy", 8'(busy), 8'd0);
    tick();

    // MOVC_DP wait, stall toggling
    start = 1; op_class = 4;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      stall = 1'(i);
      #1;
      chk("movc_sel3", 8'(sel3), 8'd0);
      chk("movc_done", 8'(done), 8'd0);
      tick();
    end
    stall = 1; mem_ack = 1;
    #1;
    chk("movc_ack_sel3", 8'(sel3), 8'd0);
    chk("movc_ack_done", 8'(done), 8'd1);
    tick();
    mem_ack = 0; stall = 0;
    #1;
    chk("movc_end_sel3", 8'(sel3), 8'd1);
    chk("movc_end_busy", 8'(busy), 8'd0);
    tick();

    // MULDIV with a start pulse while busy
    start = 1; op_class = 6;
    tick();
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      #1;
      chk("md_sel1", 8'(sel1), 8'd1);
      chk("md_sel2", 8'(sel2), 8'd2);
      chk("md_step", 8'(step), 8'(i));
      chk("md_done", 8'(done), 8'(i == 3));
      tick();
    end
    start = 0;
    #1;
    chk("md_end_busy", 8'(busy), 8'd0);
`ifdef OC8051_ALU_SRC_CTRL_ERR_EN
    chk("md_err", 8'(err), 8'd1);
`else
    chk("md_err", 8'(err), 8'd0);
`endif
    tick();

    // start held high with ALU_RAM
    start = 1; op_class = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("hold_busy", 8'(busy), 8'(i % 2 == 0));
      chk("hold_done", 8'(done), 8'(i % 2 == 0));
      tick();
    end
    start = 0;
    tick(); tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 2) == 0);
      op_class = 3'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      mem_ack  = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 0; start = 0; stall = 0; mem_ack = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/oc8051_alu_src_ctrl.md
Name: oc8051_alu_src_ctrl

Overview:
- Sequencer that drives the ALU source-select codes (sel1/sel2/sel3) for the 8051 ALU operand mux, one step per clock.
- Accepts a decoded instruction class and a start pulse from the decoder, then steps through 1..N select cycles.
- Handles memory wait (MOVC) and pipeline stall, and reports busy/done to the decoder.

Parameters:
- MULDIV_CYC, 4, number of EXEC steps for class MULDIV (legal 2..15).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin a new sequence.
- op_class  input  3  decoded class, sampled when start is accepted.
- stall  input  1  pipeline stall; freezes sequencing in EXEC.
- mem_ack  input  1  program-memory read complete, used by MOVC classes.
- sel1  output  3  src1 select: RAM=0, ACC=1, OP1=2, OP2=3, OP3=4, PCH=5, PCL=6.
- sel2  output  2  src2 select: ACC=0, ZERO=1, RAM=2, OP2=3.
- sel3  output  1  src3 select: DP=0, PC=1.
- step  output  4  current step index within the sequence.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse on the final step.
- err  output  1  sticky protocol error (optional feature).

Behaviour:
- Reset values:
  - sel1=1 (ACC), sel2=1 (ZERO), sel3=1 (PC).
  - step=0, busy=0, done=0, err=0, state=IDLE.
- sel1, sel2, sel3, step and busy are registered. done is combinational from state, step, stall and mem_ack.
- States: IDLE, EXEC, WAIT.
- Accept:
  - In IDLE, start=1 and stall=0 at an edge latches op_class.
  - From the next cycle: step=0, busy=1, step-0 selects driven.
  - In IDLE with stall=1, start is ignored.
  - start while busy=1 is ignored.
- Per-class step table (sel1/sel2/sel3 per step):
  - 0 NOP: 1 step; ACC/ZERO/PC.
  - 1 ALU_RAM: 1 step; ACC/RAM/PC.
  - 2 ALU_IMM: 1 step; ACC/OP2/PC.
  - 3 CALL: 2 steps; step0 PCL/ZERO/PC, step1 PCH/ZERO/PC.
  - 4 MOVC_DP: enter WAIT; ACC/ZERO/DP.
  - 5 MOVC_PC: enter WAIT; ACC/ZERO/PC.
  - 6 MULDIV: MULDIV_CYC steps, all ACC/RAM/PC; step counts 0..MULDIV_CYC-1.
  - 7 OP3: 3 steps; step0 OP1/ZERO/PC, step1 OP2/ZERO/PC, step2 OP3/ZERO/PC.
- EXEC:
  - stall=0: step advances each edge. On the last step, done=1 and the next edge returns to IDLE.
  - stall=1: step, selects and state hold; done forced 0.
- WAIT:
  - Selects hold; stall is ignored.
  - done = mem_ack; the edge with mem_ack=1 returns to IDLE.
- Return to IDLE: busy=0, step=0, selects go to reset defaults. At least one idle cycle separates sequences; there is no back-to-back accept.
- mem_ack outside WAIT is ignored.
- rst asserted mid-sequence aborts immediately to reset values; no done pulse is produced.

Optional Feature:
- Macro: OC8051_ALU_SRC_CTRL_ERR_EN.
- Defined: err is set at any edge where start=1 and busy=1, or where mem_ack=1 and state is not WAIT. err stays set until rst.
- Undefined: err is tied to 0 and no error logic is built.

Test Plan:
- Reset mid-CALL (rst during step 1) -> same cycle: sel1=1, sel2=1, sel3=1, busy=0, step=0; no done pulse.
- start with op_class=3, no stall -> cycle+1: sel1=6, sel2=1, busy=1, step=0; cycle+2: sel1=5, step=1, done=1; cycle+3: busy=0, sel1=1.
- op_class=7 with stall=1 on step 1 for 3 cycles -> sel1=3 held 4 cycles with done=0; then sel1=4, done=1; then IDLE.
- op_class=4, mem_ack after 5 cycles -> sel3=0 for 6 cycles, done=1 only in the mem_ack cycle; stall toggling meanwhile has no effect; then sel3=1.
- op_class=6 with MULDIV_CYC=4 -> 4 cycles sel1=1, sel2=2, step 0..3, done at step 3; start pulsed during busy is ignored, and with ERR_EN defined err=1.
- start held high continuously with op_class=1 -> pattern busy 1,0,1,0…, each sequence 1 step with done=1.
